// File: rtl/alu_issue.sv
// RV32I integer-ALU issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU operands and presents
// them from a registered output stage backed by a one-entry skid buffer.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`endif

module alu_issue (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [`CPU_WIDTH-1:0]    in_pc,
  input  logic [`CPU_WIDTH-1:0]    in_rs1_data,
  input  logic [`CPU_WIDTH-1:0]    in_rs2_data,
  input  logic                     flush,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [`ALU_OP_WIDTH-1:0] alu_op,
  output logic [`CPU_WIDTH-1:0]    alu_src1,
  output logic [`CPU_WIDTH-1:0]    alu_src2,
  output logic [4:0]               rd_idx,
  output logic                     rd_wen,
  output logic                     illegal
);

  localparam int unsigned XLEN = `CPU_WIDTH;
  localparam int unsigned OPW  = `ALU_OP_WIDTH;
  localparam int unsigned PW   = OPW + 2 * XLEN + 7;

  // Payload layout: {op, src1, src2, rd, wen, illegal}
  localparam logic [PW-1:0] RstPay = {`ALU_ADD, {(PW - OPW){1'b0}}};

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  logic [OPW-1:0]  w_op;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;
  logic            w_legal;
  logic [PW-1:0]   w_dec;
  logic            unused_rs1_field;

  assign w_opcode = in_inst[6:0];
  assign w_rd     = in_inst[11:7];
  assign w_f3     = in_inst[14:12];
  assign w_f7     = in_inst[31:25];
  assign unused_rs1_field = ^in_inst[19:15];

  always_comb begin
    w_op    = `ALU_ADD;
    w_src1  = '0;
    w_src2  = '0;
    w_legal = 1'b0;
    case (w_opcode)
      7'b0110011: begin
        w_src1  = in_rs1_data;
        w_src2  = in_rs2_data;
        w_legal = (w_f7 == 7'b0000000);
        case (w_f3)
          3'b000: begin
            w_op    = (w_f7 == 7'b0100000) ? `ALU_SUB : `ALU_ADD;
            w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
          end
          3'b001: w_op = `ALU_SLL;
          3'b010: w_op = `ALU_SLT;
          3'b011: w_op = `ALU_SLTU;
          3'b100: w_op = `ALU_XOR;
          3'b101: begin
            w_op    = (w_f7 == 7'b0100000) ? `ALU_SRA : `ALU_SRL;
            w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
          end
          3'b110: w_op = `ALU_OR;
          default: w_op = `ALU_AND;
        endcase
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          w_src2 = {{(XLEN - 5){1'b0}}, in_rs2_data[4:0]};
        end
      end
      7'b0010011: begin
        w_src1  = in_rs1_data;
        w_src2  = {{(XLEN - 12){in_inst[31]}}, in_inst[31:20]};
        w_legal = 1'b1;
        case (w_f3)
          3'b000: w_op = `ALU_ADD;
          3'b001: begin
            w_op    = `ALU_SLL;
            w_legal = (w_f7 == 7'b0000000);
          end
          3'b010: w_op = `ALU_SLT;
          3'b011: w_op = `ALU_SLTU;
          3'b100: w_op = `ALU_XOR;
          3'b101: begin
            w_op    = (w_f7 == 7'b0100000) ? `ALU_SRA : `ALU_SRL;
            w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
          end
          3'b110: w_op = `ALU_OR;
          default: w_op = `ALU_AND;
        endcase
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          w_src2 = {{(XLEN - 5){1'b0}}, in_inst[24:20]};
        end
      end
      7'b0110111: begin
        w_src2  = {in_inst[31:12], 12'b0};
        w_legal = 1'b1;
      end
      7'b0010111: begin
        w_src1  = in_pc;
        w_src2  = {in_inst[31:12], 12'b0};
        w_legal = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    // Undecodable words still issue, but as a harmless ADD 0,0 with no writeback
    if (!w_legal) begin
      w_op   = `ALU_ADD;
      w_src1 = '0;
      w_src2 = '0;
    end
  end

  assign w_dec = {w_op, w_src1, w_src2, w_rd, w_legal && (w_rd != 5'd0), !w_legal};

  logic          r_out_v, r_skid_v;
  logic [PW-1:0] r_out, r_skid;
  logic          w_out_v_nxt, w_skid_v_nxt;
  logic [PW-1:0] w_out_nxt, w_skid_nxt;
  logic          w_accept, w_consume, w_out_free;

  assign w_accept   = in_valid && !r_skid_v;
  assign w_consume  = r_out_v && ex_ready;
  assign w_out_free = !r_out_v || w_consume;

  always_comb begin
    w_out_v_nxt  = r_out_v;
    w_skid_v_nxt = r_skid_v;
    w_out_nxt    = r_out;
    w_skid_nxt   = r_skid;
    if (flush) begin
      w_out_v_nxt  = 1'b0;
      w_skid_v_nxt = 1'b0;
    end else if (w_out_free) begin
      if (r_skid_v) begin
        w_out_nxt    = r_skid;
        w_out_v_nxt  = 1'b1;
        w_skid_v_nxt = 1'b0;
      end else begin
        w_out_v_nxt = w_accept;
        if (w_accept) w_out_nxt = w_dec;
      end
    end else if (w_accept) begin
      w_skid_nxt   = w_dec;
      w_skid_v_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
      r_out    <= RstPay;
      r_skid   <= '0;
    end else begin
      r_out_v  <= w_out_v_nxt;
      r_skid_v <= w_skid_v_nxt;
      r_out    <= w_out_nxt;
      r_skid   <= w_skid_nxt;
    end
  end

  // in_ready comes straight from the skid flop, so ex_ready never reaches it combinationally
  assign in_ready = !r_skid_v;
  assign ex_valid = r_out_v;
  assign {alu_op, alu_src1, alu_src2, rd_idx, rd_wen, illegal} = r_out;

endmodule

// File: tb/tb_alu_issue.sv
// Randomised and directed bench for alu_issue against a two-deep FIFO model of decoded
// instructions.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`endif

module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [4:0]  rd_idx;
  logic        rd_wen;
  logic        illegal;

  alu_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .alu_op      (alu_op),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .rd_idx      (rd_idx),
    .rd_wen      (rd_wen),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  exp_t mq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural meaning of each instruction, from the ISA tables
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [3:0] base_ops[8];
    exp_t       e;
    logic [6:0] opc;
    logic [6:0] f7;
    int         f3;
    bit         ok;
    logic [31:0] imm;
    base_ops = '{`ALU_ADD, `ALU_SLL, `ALU_SLT, `ALU_SLTU, `ALU_XOR, `ALU_SRL, `ALU_OR, `ALU_AND};
    opc = inst[6:0];
    f7  = inst[31:25];
    f3  = int'(inst[14:12]);
    imm = 32'($signed(inst[31:20]));
    ok  = 1'b0;
    e   = '{op: `ALU_ADD, s1: 32'd0, s2: 32'd0, rd: inst[11:7], wen: 1'b0, ill: 1'b1};
    if (opc == 7'h33) begin
      e.s1 = a;
      e.s2 = (f3 == 1 || f3 == 5) ? (b % 32) : b;
      if (f7 == 7'h00) begin
        ok = 1'b1;
        e.op = base_ops[f3];
      end else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin
        ok = 1'b1;
        e.op = (f3 == 0) ? `ALU_SUB : `ALU_SRA;
      end
    end else if (opc == 7'h13) begin
      e.s1 = a;
      e.s2 = (f3 == 1 || f3 == 5) ? 32'(inst[24:20]) : imm;
      e.op = base_ops[f3];
      ok   = 1'b1;
      if (f3 == 1) ok = (f7 == 7'h00);
      if (f3 == 5) begin
        ok = (f7 == 7'h00) || (f7 == 7'h20);
        if (f7 == 7'h20) e.op = `ALU_SRA;
      end
    end else if (opc == 7'h37 || opc == 7'h17) begin
      ok   = 1'b1;
      e.op = `ALU_ADD;
      e.s1 = (opc == 7'h17) ? pc : 32'd0;
      e.s2 = inst & 32'hFFFF_F000;
    end
    if (ok) begin
      e.ill = 1'b0;
      e.wen = (e.rd != 5'd0);
    end else begin
      e.op = `ALU_ADD;
      e.s1 = 32'd0;
      e.s2 = 32'd0;
    end
    return e;
  endfunction

  task automatic compare_outputs();
    exp_t e;
    check("ex_valid", 64'(ex_valid), 64'(mq.size() > 0));
    check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    if (mq.size() > 0) begin
      e = mq[0];
      check("alu_op", 64'(alu_op), 64'(e.op));
      check("alu_src1", 64'(alu_src1), 64'(e.s1));
      check("alu_src2", 64'(alu_src2), 64'(e.s2));
      check("rd_idx", 64'(rd_idx), 64'(e.rd));
      check("rd_wen", 64'(rd_wen), 64'(e.wen));
      check("illegal", 64'(illegal), 64'(e.ill));
    end
  endtask

  // One clock: update the model with the inputs held across the edge, then sample 1 ns later
  task automatic tick(output bit acc);
    acc = in_valid && (mq.size() < 2);
    @(posedge clk);
    if (flush) begin
      mq.delete();
      acc = 1'b0;
    end else begin
      if (mq.size() > 0 && ex_ready) void'(mq.pop_front());
      if (acc) mq.push_back(ref_decode(in_inst, in_pc, in_rs1_data, in_rs2_data));
    end
    #1;
    compare_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".ex_valid"}, 64'(ex_valid), 64'(0));
    check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
    check({tag, ".alu_op"}, 64'(alu_op), 64'(`ALU_ADD));
    check({tag, ".src1"}, 64'(alu_src1), 64'(0));
    check({tag, ".src2"}, 64'(alu_src2), 64'(0));
    check({tag, ".rd_idx"}, 64'(rd_idx), 64'(0));
    check({tag, ".rd_wen"}, 64'(rd_wen), 64'(0));
    check({tag, ".illegal"}, 64'(illegal), 64'(0));
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  task automatic issue_one(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [3:0] eop, input logic [31:0] es1,
                           input logic [31:0] es2, input logic [4:0] erd,
                           input logic ewen, input logic eill);
    bit acc;
    in_valid = 1'b1; in_inst = inst; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
    ex_ready = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    check({tag, ".valid"}, 64'(ex_valid), 64'(1));
    check({tag, ".op"}, 64'(alu_op), 64'(eop));
    check({tag, ".src1"}, 64'(alu_src1), 64'(es1));
    check({tag, ".src2"}, 64'(alu_src2), 64'(es2));
    check({tag, ".rd"}, 64'(rd_idx), 64'(erd));
    check({tag, ".wen"}, 64'(rd_wen), 64'(ewen));
    check({tag, ".ill"}, 64'(illegal), 64'(eill));
    tick(acc);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  opcs[5];
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h00};
    w = $urandom;
    w[6:0] = opcs[$urandom_range(0, 4)];
    if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
    case ($urandom_range(0, 2))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  logic [31:0] bp_insts[3];
  logic [4:0]  seen[$];

  initial begin
    bit acc;
    int idx;
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    in_rs1_data = '0; in_rs2_data = '0; flush = 1'b0; ex_ready = 1'b0;
    #12;
    check_reset_values("reset");
    rst_n = 1'b1;

    issue_one("addi", 32'hFFF0_8293, 32'h0, 32'd5, 32'd0,
              `ALU_ADD, 32'd5, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0);
    issue_one("sub", r_type(7'h20, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33), 32'h0, 32'd7, 32'd9,
              `ALU_SUB, 32'd7, 32'd9, 5'd1, 1'b1, 1'b0);
    issue_one("srai", 32'h4041_D193, 32'h0, 32'h8000_0000, 32'd0,
              `ALU_SRA, 32'h8000_0000, 32'd4, 5'd3, 1'b1, 1'b0);
    issue_one("slli_bad", r_type(7'h20, 5'd3, 5'd1, 3'd1, 5'd2, 7'h13), 32'h0, 32'd11, 32'd0,
              `ALU_ADD, 32'd0, 32'd0, 5'd2, 1'b0, 1'b1);
    issue_one("lui", 32'h1234_5137, 32'h40, 32'd99, 32'd98,
              `ALU_ADD, 32'd0, 32'h1234_5000, 5'd2, 1'b1, 1'b0);
    issue_one("auipc", 32'h0000_1097, 32'h100, 32'd99, 32'd98,
              `ALU_ADD, 32'h100, 32'h1000, 5'd1, 1'b1, 1'b0);
    issue_one("add_x0", r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33), 32'h0, 32'd3, 32'd4,
              `ALU_ADD, 32'd3, 32'd4, 5'd0, 1'b0, 1'b0);
    issue_one("op7f", 32'h0000_007F, 32'h0, 32'd3, 32'd4,
              `ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    issue_one("sra_shamt", r_type(7'h20, 5'd2, 5'd1, 3'd5, 5'd6, 7'h33), 32'h0, 32'd1,
              32'h0000_0123, `ALU_SRA, 32'd1, 32'd3, 5'd6, 1'b1, 1'b0);

    // Backpressure: three ADDIs to x1, x2, x3 against a stalled execute stage
    bp_insts[0] = 32'h0010_0093;
    bp_insts[1] = 32'h0020_0113;
    bp_insts[2] = 32'h0030_0193;
    ex_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 3); in_inst = bp_insts[idx % 3]; in_rs1_data = 32'(c);
      tick(acc);
      if (acc) idx++;
    end
    check("bp.in_ready_stalled", 64'(in_ready), 64'(0));
    check("bp.accepted", 64'(idx), 64'(2));
    ex_ready = 1'b1;
    for (int c = 0; c < 20 && seen.size() < 3; c++) begin
      if (ex_valid && ex_ready) seen.push_back(rd_idx);
      in_valid = (idx < 3); in_inst = bp_insts[idx % 3];
      tick(acc);
      if (acc) idx++;
    end
    check("bp.drained_count", 64'(seen.size()), 64'(3));
    for (int k = 0; k < 3 && k < seen.size(); k++) check("bp.order", 64'(seen[k]), 64'(k + 1));
    in_valid = 1'b0;
    tick(acc);

    // Flush with both entries full and a live input
    ex_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_inst = bp_insts[c];
      tick(acc);
    end
    in_valid = 1'b1; in_inst = 32'h0070_0393; flush = 1'b1;
    tick(acc);
    flush = 1'b0; in_valid = 1'b0;
    check("flush.ex_valid", 64'(ex_valid), 64'(0));
    check("flush.in_ready", 64'(in_ready), 64'(1));
    ex_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(acc);
      check("flush.no_ghost", 64'(ex_valid), 64'(0));
    end

    // Asynchronous reset in the middle of a cycle with both entries full
    ex_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_inst = bp_insts[c];
      tick(acc);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    mq.delete();
    #3 rst_n = 1'b1;

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      ex_ready    = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 39) == 0);
      in_inst     = rand_inst();
      in_pc       = $urandom;
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      tick(acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
